// File: rtl/xbar_pkg.sv
// Shared types and width helpers for the crossbar arbiters.
package xbar_pkg;

  typedef enum logic {ARB_IDLE, ARB_WLOCK} arb_state_e;

  // Index width that never collapses to zero for a single-entry range.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at masters.
module rr_pick #(
  parameter int unsigned masters = 2,
  parameter int unsigned MST_W   = 1
) (
  input  logic [masters-1:0] req,
  input  logic [MST_W-1:0]   ptr,
  output logic [MST_W-1:0]   winner,
  output logic               any
);

  localparam int unsigned IW = MST_W + 1;

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < int'(masters); i++) begin
      idx = {1'b0, ptr} + IW'(i);
      // Explicit wrap so non-power-of-two master counts stay in range.
      if (idx >= IW'(masters)) idx = idx - IW'(masters);
      if (!any && req[idx[MST_W-1:0]]) begin
        winner = idx[MST_W-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_forward_arbiter.sv
// Per-slave round-robin arbiter for one forward channel (AR or AW); the AW flavour
// holds the slave's W path for the winning master until its WLAST beat is pushed.
module xbar_forward_arbiter
  import xbar_pkg::*;
#(
  parameter int unsigned masters           = 2,
  parameter int unsigned slaves            = 2,
  parameter int unsigned i_am_slave_number = 0,
  parameter int unsigned LOCK_WDATA        = 0
) (
  input  logic                                      ACLK,
  input  logic                                      ARESETn,
  input  logic [masters-1:0]                        master_fifo_empty,
  input  logic [masters-1:0][clog2_safe(slaves)-1:0] master_dest_slave,
  input  logic                                      slave_fifo_full,
  input  logic                                      wdata_push,
  input  logic                                      wdata_last,
  output logic                                      grant_valid,
  output logic [clog2_safe(masters)-1:0]            grant_master_number,
  output logic                                      slave_fifo_push,
  output logic                                      wlock_valid,
  output logic [clog2_safe(masters)-1:0]            wlock_master_number
);

  localparam int unsigned MST_W = clog2_safe(masters);
  localparam int unsigned SLV_W = clog2_safe(slaves);

  localparam logic [SLV_W-1:0] MySlave = SLV_W'(i_am_slave_number);
  localparam logic [MST_W-1:0] LastMst = MST_W'(masters - 1);
  localparam bit               LockEn  = (LOCK_WDATA != 0);

  logic [masters-1:0] req;
  logic [MST_W-1:0]   winner;
  logic               any;
  logic               accept;

  logic [MST_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [MST_W-1:0]   owner_q, owner_d;
  logic [MST_W-1:0]   last_q, last_d;
  arb_state_e         state_q, state_d;

  always_comb begin
    req = '0;
    for (int unsigned m = 0; m < masters; m++) begin
      req[m] = !master_fifo_empty[m] && (master_dest_slave[m] == MySlave);
    end
  end

  rr_pick #(
    .masters (masters),
    .MST_W   (MST_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .any    (any)
  );

  // Gated by ARESETn so the grant drops the instant reset asserts, without a clock.
  assign accept = ARESETn && any && !slave_fifo_full && (!LockEn || state_q == ARB_IDLE);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    last_d   = last_q;
    state_d  = state_q;
    if (accept) begin
      rr_ptr_d = (winner == LastMst) ? '0 : winner + MST_W'(1);
      last_d   = winner;
      if (LockEn) begin
        state_d = ARB_WLOCK;
        owner_d = winner;
      end
    end else if (state_q == ARB_WLOCK && wdata_push && wdata_last) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      last_q   <= '0;
      state_q  <= ARB_IDLE;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      state_q  <= state_d;
    end
  end

  always_comb begin
    grant_valid         = accept;
    slave_fifo_push     = accept;
    grant_master_number = accept ? winner : last_q;
    wlock_valid         = LockEn && (state_q == ARB_WLOCK);
    wlock_master_number = LockEn ? owner_q : '0;
  end

endmodule
